// File: rtl/async_fifo16_wr_sched_pkg.sv
// Shared constants and types for the async_fifo16 write-side scheduler.
//   FIFO16_DEPTH : bit depth of async_fifo16, also the initial/maximum credit count
//   FRAME_ID_W   : width of the requester ID field at the head of each frame
//   sched_state_t: scheduler FSM states
package async_lib_pkg;

   localparam int FIFO16_DEPTH = 16;
   localparam int FRAME_ID_W   = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } sched_state_t;

endpackage

// File: rtl/async_fifo16_wr_sched_if.sv
// Requester / FIFO-side bundle of the write scheduler.
//   REQ, DATA, ACK        : word requesters (DATA word i at [i*DATA_W +: DATA_W])
//   CREDIT_RET            : one pulse per bit freed on the FIFO read side (already in W_CLK)
//   FIFO_DIN, FIFO_DIN_DV : serial write port into async_fifo16
// master = the system side (requesters + FIFO), slave = the scheduler.
interface async_fifo16_wr_sched_if #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8
) ();

   logic [N_REQ-1:0]        REQ;
   logic [N_REQ*DATA_W-1:0] DATA;
   logic [N_REQ-1:0]        ACK;
   logic                    CREDIT_RET;
   logic                    FIFO_DIN;
   logic                    FIFO_DIN_DV;

   modport master (
      output REQ, DATA, CREDIT_RET,
      input  ACK, FIFO_DIN, FIFO_DIN_DV
   );

   modport slave (
      input  REQ, DATA, CREDIT_RET,
      output ACK, FIFO_DIN, FIFO_DIN_DV
   );

endinterface

// File: rtl/async_fifo16_wr_sched_rr_arbiter.sv
// Combinational round-robin pick.
//   req        : request vector
//   last_grant : index granted last time; search starts at last_grant+1 mod N_REQ
//   valid      : at least one request present
//   winner     : index of the first requester found
module rr_arbiter
   import async_lib_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]      req,
   input  logic [FRAME_ID_W-1:0] last_grant,
   output logic                  valid,
   output logic [FRAME_ID_W-1:0] winner
);

   int best_d;
   int d;

   // Each requester's distance from the search start; the smallest requesting one wins.
   always_comb begin
      valid  = 1'b0;
      winner = '0;
      best_d = N_REQ;
      d      = 0;
      for (int i = 0; i < N_REQ; i++) begin
         d = (i + N_REQ - 1 - int'(last_grant)) % N_REQ;
         if (req[i] && (d < best_d)) begin
            best_d = d;
            valid  = 1'b1;
            winner = FRAME_ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/async_fifo16_wr_sched.sv
// Write-side scheduler for the 1-bit, 16-deep async_fifo16 (W_CLK domain).
// Shares the FIFO among N_REQ word requesters by round robin and serializes each
// granted word MSB-first as {id[1:0], data}. Writes are paced by a credit counter
// since the FIFO has no full flag.
//   CLK        : write clock (FIFO W_CLK)
//   RST        : synchronous, active-high
//   bus        : requester handshake, credit return and FIFO write port
//   BUSY       : frame being shifted
//   CREDITS    : free FIFO bits, 0..DEPTH
//   CREDIT_ERR : sticky, credit returned while already at DEPTH
//
// state | meaning
// IDLE  | waiting for a request with at least FRAME_LEN credits
// SHIFT | driving the remaining bits of the current frame
module async_fifo16_wr_sched
   import async_lib_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8,
   parameter int DEPTH  = FIFO16_DEPTH
) (
   input  logic                    CLK,
   input  logic                    RST,
   async_fifo16_wr_sched_if.slave  bus,
   output logic                    BUSY,
   output logic [4:0]              CREDITS,
   output logic                    CREDIT_ERR
);

   localparam int FRAME_LEN = DATA_W + FRAME_ID_W;
   localparam int CNT_W     = $clog2(FRAME_LEN);

   sched_state_t            state_q, state_nxt;
   logic [FRAME_ID_W-1:0]   last_grant_q, last_grant_nxt;
   logic [FRAME_LEN-1:0]    shreg_q, shreg_nxt;
   logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_nxt;
   logic [N_REQ-1:0]        ack_q, ack_nxt;
   logic                    din_q, din_nxt;
   logic                    dv_q, dv_nxt;
   logic                    busy_q;
   logic [4:0]              credits_q, credits_nxt;
   logic                    err_q, err_nxt;

   logic                    arb_valid;
   logic [FRAME_ID_W-1:0]   arb_winner;
   logic [DATA_W-1:0]       word;
   logic [FRAME_LEN-1:0]    frame;
   logic                    grant;

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_arb (
      .req        (bus.REQ),
      .last_grant (last_grant_q),
      .valid      (arb_valid),
      .winner     (arb_winner)
   );

   always_comb begin
      word = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_winner == FRAME_ID_W'(i)) begin
            word = bus.DATA[i*DATA_W +: DATA_W];
         end
      end
   end

   assign frame = {arb_winner, word};
   assign grant = (state_q == IDLE) && arb_valid && (credits_q >= 5'(FRAME_LEN));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         IDLE:    if (grant) state_nxt = SHIFT;
         SHIFT:   if (bit_cnt_q == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The first frame bit leaves on the grant edge, so shreg keeps only the
   // remaining bits and bit_cnt counts the bits still to send.
   always_comb begin
      ack_nxt        = '0;
      din_nxt        = 1'b0;
      dv_nxt         = 1'b0;
      shreg_nxt      = shreg_q;
      bit_cnt_nxt    = bit_cnt_q;
      last_grant_nxt = last_grant_q;
      unique case (state_q)
         IDLE: begin
            if (grant) begin
               for (int i = 0; i < N_REQ; i++) begin
                  ack_nxt[i] = (arb_winner == FRAME_ID_W'(i));
               end
               din_nxt        = frame[FRAME_LEN-1];
               dv_nxt         = 1'b1;
               shreg_nxt      = frame << 1;
               bit_cnt_nxt    = CNT_W'(FRAME_LEN - 1);
               last_grant_nxt = arb_winner;
            end
         end
         SHIFT: begin
            if (bit_cnt_q != '0) begin
               din_nxt     = shreg_q[FRAME_LEN-1];
               dv_nxt      = 1'b1;
               shreg_nxt   = shreg_q << 1;
               bit_cnt_nxt = bit_cnt_q - CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   // A write and a return in the same cycle cancel; a return at DEPTH is dropped and flagged.
   always_comb begin
      credits_nxt = credits_q;
      err_nxt     = err_q;
      if (bus.CREDIT_RET && !dv_q) begin
         if (credits_q == 5'(DEPTH)) begin
            err_nxt = 1'b1;
         end else begin
            credits_nxt = credits_q + 5'd1;
         end
      end else if (!bus.CREDIT_RET && dv_q) begin
         if (credits_q != 5'd0) begin
            credits_nxt = credits_q - 5'd1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         last_grant_q <= FRAME_ID_W'(N_REQ - 1);
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         ack_q        <= '0;
         din_q        <= 1'b0;
         dv_q         <= 1'b0;
         busy_q       <= 1'b0;
         credits_q    <= 5'(DEPTH);
         err_q        <= 1'b0;
      end else begin
         last_grant_q <= last_grant_nxt;
         shreg_q      <= shreg_nxt;
         bit_cnt_q    <= bit_cnt_nxt;
         ack_q        <= ack_nxt;
         din_q        <= din_nxt;
         dv_q         <= dv_nxt;
         busy_q       <= (state_nxt == SHIFT);
         credits_q    <= credits_nxt;
         err_q        <= err_nxt;
      end
   end

   assign bus.ACK         = ack_q;
   assign bus.FIFO_DIN    = din_q;
   assign bus.FIFO_DIN_DV = dv_q;
   assign BUSY            = busy_q;
   assign CREDITS         = credits_q;
   assign CREDIT_ERR      = err_q;

endmodule

// File: tb/tb_async_fifo16_wr_sched.sv
module tb_async_fifo16_wr_sched;
   import async_lib_pkg::*;

   localparam int N_REQ     = 4;
   localparam int DATA_W    = 8;
   localparam int DEPTH     = 16;
   localparam int FRAME_LEN = DATA_W + 2;

   logic       CLK = 1'b0;
   logic       RST;
   logic       BUSY;
   logic [4:0] CREDITS;
   logic       CREDIT_ERR;

   async_fifo16_wr_sched_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

   async_fifo16_wr_sched #(
      .N_REQ  (N_REQ),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .bus        (bus),
      .BUSY       (BUSY),
      .CREDITS    (CREDITS),
      .CREDIT_ERR (CREDIT_ERR)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;

   always @(posedge CLK) cyc++;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a frame is a bit queue filled at grant; credits are plain integers.
   int       m_credits;
   bit       m_err;
   int       m_last;
   bit       m_bits[$];
   bit [3:0] m_ack;
   bit       m_din, m_dv, m_busy;

   task automatic model_reset();
      m_credits = DEPTH;
      m_err     = 1'b0;
      m_last    = N_REQ - 1;
      m_bits.delete();
      m_ack     = '0;
      m_din     = 1'b0;
      m_dv      = 1'b0;
      m_busy    = 1'b0;
   endtask

   always @(posedge CLK) begin
      int            c;
      int            w;
      bit [3:0]      next_ack;
      logic [9:0]    fr;
      logic [7:0]    wd;
      if (RST) begin
         model_reset();
      end else begin
         c = m_credits - int'(m_dv) + int'(bus.CREDIT_RET);
         if (c > DEPTH) begin
            c     = DEPTH;
            m_err = 1'b1;
         end
         if (c < 0) c = 0;
         next_ack = '0;
         if (m_busy) begin
            if (m_bits.size() > 0) begin
               m_din = m_bits.pop_front();
               m_dv  = 1'b1;
            end else begin
               m_din  = 1'b0;
               m_dv   = 1'b0;
               m_busy = 1'b0;
            end
         end else if (bus.REQ != '0 && m_credits >= FRAME_LEN) begin
            w = -1;
            for (int k = 1; k <= N_REQ; k++) begin
               if (w < 0 && bus.REQ[(m_last + k) % N_REQ]) w = (m_last + k) % N_REQ;
            end
            wd = bus.DATA[w*DATA_W +: DATA_W];
            fr = {w[1:0], wd};
            for (int b = FRAME_LEN - 1; b >= 0; b--) m_bits.push_back(fr[b]);
            m_din       = m_bits.pop_front();
            m_dv        = 1'b1;
            m_busy      = 1'b1;
            next_ack[w] = 1'b1;
            m_last      = w;
         end else begin
            m_din = 1'b0;
            m_dv  = 1'b0;
         end
         m_ack     = next_ack;
         m_credits = c;
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         check("model_ack",     int'(bus.ACK),         int'(m_ack));
         check("model_din",     int'(bus.FIFO_DIN),    int'(m_din));
         check("model_dv",      int'(bus.FIFO_DIN_DV), int'(m_dv));
         check("model_busy",    int'(BUSY),            int'(m_busy));
         check("model_credits", int'(CREDITS),         m_credits);
         check("model_err",     int'(CREDIT_ERR),      int'(m_err));
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while ((BUSY || bus.FIFO_DIN_DV) && n < 40) begin
         @(negedge CLK);
         n++;
      end
      check("wait_idle", int'(BUSY), 0);
   endtask

   task automatic replenish(input int n);
      for (int i = 0; i < n; i++) begin
         bus.CREDIT_RET = 1'b1;
         @(negedge CLK);
      end
      bus.CREDIT_RET = 1'b0;
   endtask

   task automatic pulse_reset();
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
   endtask

   typedef struct {
      logic [3:0] req;
      int         exp_idx;
   } arb_vec_t;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      arb_vec_t   vec[11];
      logic [9:0] exp_frame;
      int         idx;
      int         n_ack;
      bit         pend;
      int         idx_a[5];
      int         cyc_a[5];
      int         id_a[5];
      bit         saw_gap;

      vec[0]  = '{4'b0100, 2};
      vec[1]  = '{4'b1111, 3};
      vec[2]  = '{4'b1111, 0};
      vec[3]  = '{4'b1111, 1};
      vec[4]  = '{4'b0101, 2};
      vec[5]  = '{4'b0001, 0};
      vec[6]  = '{4'b1010, 1};
      vec[7]  = '{4'b1010, 3};
      vec[8]  = '{4'b1000, 3};
      vec[9]  = '{4'b0110, 1};
      vec[10] = '{4'b0011, 0};

      RST            = 1'b1;
      bus.REQ        = '0;
      bus.DATA       = '0;
      bus.CREDIT_RET = 1'b0;
      repeat (3) @(negedge CLK);
      RST    = 1'b0;
      chk_en = 1'b1;

      check("rst_ack",     int'(bus.ACK),         0);
      check("rst_din",     int'(bus.FIFO_DIN),    0);
      check("rst_dv",      int'(bus.FIFO_DIN_DV), 0);
      check("rst_busy",    int'(BUSY),            0);
      check("rst_credits", int'(CREDITS),         DEPTH);
      check("rst_err",     int'(CREDIT_ERR),      0);

      // single requester, word A5 from requester 2
      bus.DATA[2*DATA_W +: DATA_W] = 8'hA5;
      bus.REQ = 4'b0100;
      @(negedge CLK);
      check("single_ack", int'(bus.ACK), 4'b0100);
      bus.REQ   = '0;
      exp_frame = {2'd2, 8'hA5};
      for (int i = 0; i < FRAME_LEN; i++) begin
         if (i > 0) @(negedge CLK);
         check("single_dv",  int'(bus.FIFO_DIN_DV), 1);
         check("single_bit", int'(bus.FIFO_DIN),    int'(exp_frame[FRAME_LEN-1-i]));
      end
      @(negedge CLK);
      check("single_gap_dv",   int'(bus.FIFO_DIN_DV), 0);
      check("single_gap_busy", int'(BUSY),            0);
      check("single_credits",  int'(CREDITS),         6);

      // credit stall: 6 credits is not enough for a frame
      bus.DATA[0 +: DATA_W] = 8'h3C;
      bus.REQ = 4'b0001;
      repeat (3) begin
         @(negedge CLK);
         check("stall_ack", int'(bus.ACK), 0);
      end
      replenish(4);
      check("stall_credits10", int'(CREDITS), 10);
      check("stall_ack_still0", int'(bus.ACK), 0);
      @(negedge CLK);
      check("stall_release_ack", int'(bus.ACK), 4'b0001);
      bus.REQ = '0;
      wait_idle();
      check("stall_drained", int'(CREDITS), 0);

      // write and return in the same cycle for a whole frame
      replenish(16);
      check("refill_credits", int'(CREDITS), 16);
      bus.DATA[1*DATA_W +: DATA_W] = 8'h5A;
      bus.REQ = 4'b0010;
      @(negedge CLK);
      check("simul_ack", int'(bus.ACK), 4'b0010);
      bus.REQ        = '0;
      bus.CREDIT_RET = 1'b1;
      saw_gap        = 1'b0;
      for (int i = 0; i < 12 && !saw_gap; i++) begin
         @(negedge CLK);
         check("simul_credits", int'(CREDITS), 16);
         if (!bus.FIFO_DIN_DV) saw_gap = 1'b1;
      end
      bus.CREDIT_RET = 1'b0;
      check("simul_frame_end", int'(saw_gap), 1);
      wait_idle();

      // credit overflow
      bus.CREDIT_RET = 1'b1;
      @(negedge CLK);
      bus.CREDIT_RET = 1'b0;
      check("ovf_credits", int'(CREDITS), 16);
      check("ovf_err",     int'(CREDIT_ERR), 1);
      repeat (3) @(negedge CLK);
      check("ovf_err_sticky", int'(CREDIT_ERR), 1);

      // round robin after reset, credits held up by returns every cycle
      pulse_reset();
      check("rr_rst_err",     int'(CREDIT_ERR), 0);
      check("rr_rst_credits", int'(CREDITS),    16);
      for (int r = 0; r < N_REQ; r++) bus.DATA[r*DATA_W +: DATA_W] = 8'(8'h11 * (r + 1));
      bus.REQ        = 4'b1111;
      bus.CREDIT_RET = 1'b1;
      n_ack = 0;
      pend  = 1'b0;
      for (int c = 0; c < 80 && (n_ack < 5 || pend); c++) begin
         @(negedge CLK);
         if (pend) begin
            id_a[n_ack-1] = id_a[n_ack-1] * 2 + int'(bus.FIFO_DIN);
            pend = 1'b0;
         end
         if (bus.ACK != '0 && n_ack < 5) begin
            idx = 0;
            for (int b = N_REQ - 1; b >= 0; b--) if (bus.ACK[b]) idx = b;
            check("rr_ack_onehot", int'(bus.ACK), 1 << idx);
            idx_a[n_ack] = idx;
            cyc_a[n_ack] = cyc;
            id_a[n_ack]  = int'(bus.FIFO_DIN);
            n_ack++;
            pend = 1'b1;
            if (n_ack == 5) bus.REQ = '0;
         end
      end
      bus.CREDIT_RET = 1'b0;
      check("rr_count", n_ack, 5);
      for (int k = 0; k < n_ack; k++) begin
         check("rr_order", idx_a[k], k % N_REQ);
         check("rr_id",    id_a[k],  k % N_REQ);
         if (k > 0) check("rr_period", cyc_a[k] - cyc_a[k-1], FRAME_LEN + 1);
      end
      wait_idle();

      // reset in the middle of a frame
      replenish(12);
      bus.REQ = 4'b1000;
      @(negedge CLK);
      check("midrst_ack", int'(bus.ACK), 4'b1000);
      bus.REQ = '0;
      repeat (4) @(negedge CLK);
      check("midrst_in_frame", int'(BUSY), 1);
      pulse_reset();
      check("midrst_dv",      int'(bus.FIFO_DIN_DV), 0);
      check("midrst_busy",    int'(BUSY),            0);
      check("midrst_credits", int'(CREDITS),         16);
      check("midrst_ack0",    int'(bus.ACK),         0);
      bus.REQ = 4'b1111;
      @(negedge CLK);
      check("midrst_next_grant", int'(bus.ACK), 4'b0001);
      bus.REQ = '0;
      wait_idle();

      // table-driven arbitration sequence from reset
      pulse_reset();
      foreach (vec[i]) begin
         for (int r = 0; r < N_REQ; r++) bus.DATA[r*DATA_W +: DATA_W] = 8'($urandom);
         bus.REQ = vec[i].req;
         @(negedge CLK);
         check("table_ack", int'(bus.ACK), 1 << vec[i].exp_idx);
         bus.REQ = '0;
         wait_idle();
         replenish(10);
      end

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         @(negedge CLK);
         if ($urandom_range(0, 3) == 0) bus.REQ = 4'($urandom);
         for (int r = 0; r < N_REQ; r++) begin
            if (!bus.REQ[r]) bus.DATA[r*DATA_W +: DATA_W] = 8'($urandom);
         end
         bus.CREDIT_RET = ($urandom_range(0, 2) == 0) &&
                          ((m_credits < DEPTH) || ($urandom_range(0, 19) == 0));
         RST = ($urandom_range(0, 299) == 0);
      end
      RST            = 1'b0;
      bus.REQ        = '0;
      bus.CREDIT_RET = 1'b0;
      @(negedge CLK);
      wait_idle();

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
